// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator
// Pixel-rate prescaler, H/V raster counters, registered sync/active decode and line/frame strobes.
module vga_timing_gen #(
    parameter int   CLK_DIV  = 4,
    parameter int   CNT_W    = 10,
    parameter int   H_ACTIVE = 640,
    parameter int   H_FP     = 16,
    parameter int   H_SYNC   = 96,
    parameter int   H_BP     = 48,
    parameter int   V_ACTIVE = 480,
    parameter int   V_FP     = 10,
    parameter int   V_SYNC   = 2,
    parameter int   V_BP     = 33,
    parameter logic HS_POL   = 1'b0,
    parameter logic VS_POL   = 1'b0
) (
    input  logic             Clk,
    input  logic             vgaRst,
    input  logic             enable,
    output logic             pixelTick,
    output logic             vgaClock,
    output logic [CNT_W-1:0] hCount,
    output logic [CNT_W-1:0] vCount,
    output logic             hSync,
    output logic             vSync,
    output logic             active,
    output logic [CNT_W-1:0] xPos,
    output logic [CNT_W-1:0] yPos,
    output logic             lineStart,
    output logic             frameStart
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SS    = H_ACTIVE + H_FP;
    localparam int H_SE    = H_SS + H_SYNC - 1;
    localparam int V_SS    = V_ACTIVE + V_FP;
    localparam int V_SE    = V_SS + V_SYNC - 1;
    localparam int PW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    generate
        if (CLK_DIV < 1 || H_TOTAL > (2 ** CNT_W) || V_TOTAL > (2 ** CNT_W)) begin : g_bad_params
            $error("vga_timing_gen: CLK_DIV < 1 or raster totals do not fit in CNT_W bits");
        end
    endgenerate

    logic [PW-1:0]    presc;
    logic [PW-1:0]    presc_next;
    logic [CNT_W-1:0] h_next;
    logic [CNT_W-1:0] v_next;
    logic             tick_now;
    logic             adv;
    logic             h_wrap;
    logic             v_wrap;
    logic             hs_n;
    logic             vs_n;
    logic             act_n;
    logic             vclk_n;
    logic             line_q;
    logic             frame_q;

    always_comb begin
        tick_now   = (presc == PW'(CLK_DIV - 1));
        adv        = enable & tick_now;
        h_wrap     = (hCount == CNT_W'(H_TOTAL - 1));
        v_wrap     = (vCount == CNT_W'(V_TOTAL - 1));
        presc_next = presc;
        h_next     = hCount;
        v_next     = vCount;
        if (enable) begin
            presc_next = tick_now ? '0 : presc + PW'(1);
        end
        if (adv) begin
            if (h_wrap) begin
                h_next = '0;
                v_next = v_wrap ? '0 : vCount + CNT_W'(1);
            end else begin
                h_next = hCount + CNT_W'(1);
            end
        end
        // Decode from the next counts so the registered flags line up with the counters.
        hs_n   = (h_next >= CNT_W'(H_SS) && h_next <= CNT_W'(H_SE)) ? HS_POL : ~HS_POL;
        vs_n   = (v_next >= CNT_W'(V_SS) && v_next <= CNT_W'(V_SE)) ? VS_POL : ~VS_POL;
        act_n  = (h_next < CNT_W'(H_ACTIVE)) && (v_next < CNT_W'(V_ACTIVE));
        vclk_n = (CLK_DIV > 1) && (presc_next >= PW'(CLK_DIV / 2));
    end

    always_ff @(posedge Clk) begin
        if (vgaRst) begin
            presc    <= '0;
            hCount   <= '0;
            vCount   <= '0;
            hSync    <= ~HS_POL;
            vSync    <= ~VS_POL;
            active   <= 1'b1;
            xPos     <= '0;
            yPos     <= '0;
            vgaClock <= 1'b0;
            line_q   <= 1'b0;
            frame_q  <= 1'b0;
        end else begin
            presc    <= presc_next;
            hCount   <= h_next;
            vCount   <= v_next;
            hSync    <= hs_n;
            vSync    <= vs_n;
            active   <= act_n;
            xPos     <= act_n ? h_next : '0;
            yPos     <= act_n ? v_next : '0;
            vgaClock <= vclk_n;
            line_q   <= adv & h_wrap;
            frame_q  <= adv & h_wrap & v_wrap;
        end
    end

    assign pixelTick  = enable & ~vgaRst & tick_now;
    assign lineStart  = enable & line_q;
    assign frameStart = enable & frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - self-checking bench for vga_timing_gen
// Two instances (default timing, tiny fast raster) checked every cycle against a pixel-count model.
module tb_vga_timing_gen;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       rst_a, en_a, rst_b, en_b;
    logic       tick_a, vclk_a, hs_a, vs_a, act_a, ls_a, fs_a;
    logic [9:0] h_a, v_a, x_a, y_a;
    logic       tick_b, vclk_b, hs_b, vs_b, act_b, ls_b, fs_b;
    logic [3:0] h_b, v_b, x_b, y_b;

    vga_timing_gen dut_a (
        .Clk(Clk), .vgaRst(rst_a), .enable(en_a), .pixelTick(tick_a), .vgaClock(vclk_a),
        .hCount(h_a), .vCount(v_a), .hSync(hs_a), .vSync(vs_a), .active(act_a),
        .xPos(x_a), .yPos(y_a), .lineStart(ls_a), .frameStart(fs_a)
    );

    vga_timing_gen #(
        .CLK_DIV(1), .CNT_W(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1), .HS_POL(1'b1), .VS_POL(1'b1)
    ) dut_b (
        .Clk(Clk), .vgaRst(rst_b), .enable(en_b), .pixelTick(tick_b), .vgaClock(vclk_b),
        .hCount(h_b), .vCount(v_b), .hSync(hs_b), .vSync(vs_b), .active(act_b),
        .xPos(x_b), .yPos(y_b), .lineStart(ls_b), .frameStart(fs_b)
    );

    typedef struct {
        int div, ht, vt, ha, hs0, hs1, va, vs0, vs1;
        bit hp, vp;
        int phase;
        int pix;
        bit ls, fs;
    } model_t;

    model_t ma, mb;
    int n_checks = 0;
    int n_err = 0;
    int hs_low_cnt = 0;
    int ls_cnt_a = 0;

    function automatic model_t mk(int div, int ha, int hfp, int hsy, int hbp,
                                  int va, int vfp, int vsy, int vbp, bit hp, bit vp);
        model_t m;
        m.div = div;  m.ha = ha;  m.va = va;
        m.ht  = ha + hfp + hsy + hbp;
        m.vt  = va + vfp + vsy + vbp;
        m.hs0 = ha + hfp;  m.hs1 = ha + hfp + hsy - 1;
        m.vs0 = va + vfp;  m.vs1 = va + vfp + vsy - 1;
        m.hp = hp;  m.vp = vp;
        m.phase = 0;  m.pix = 0;  m.ls = 0;  m.fs = 0;
        return m;
    endfunction

    // The raster position is just the number of pixel periods since reset, folded by the totals.
    task automatic model_edge(inout model_t m, input bit rst, input bit en);
        bit a;
        if (rst) begin
            m.phase = 0;  m.pix = 0;  m.ls = 0;  m.fs = 0;
        end else if (en) begin
            a = (m.phase == m.div - 1);
            m.phase = (m.phase + 1) % m.div;
            if (a) m.pix = m.pix + 1;
            m.ls = a && (m.pix % m.ht == 0);
            m.fs = a && (m.pix % (m.ht * m.vt) == 0);
        end else begin
            m.ls = 0;  m.fs = 0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic check_dut(input model_t m, input bit rst, input bit en, input string p,
                             input logic tk, input logic vc, input logic [31:0] h, input logic [31:0] v,
                             input logic hs, input logic vs, input logic ac,
                             input logic [31:0] x, input logic [31:0] y, input logic ls, input logic fs);
        int eh, ev;
        bit ea;
        eh = m.pix % m.ht;
        ev = (m.pix / m.ht) % m.vt;
        ea = (eh < m.ha) && (ev < m.va);
        chk({p, "pixelTick"}, 32'(tk), 32'(en && !rst && m.phase == m.div - 1));
        chk({p, "vgaClock"}, 32'(vc), 32'(m.div > 1 && m.phase >= m.div / 2));
        chk({p, "hCount"}, h, eh);
        chk({p, "vCount"}, v, ev);
        chk({p, "hSync"}, 32'(hs), 32'((eh >= m.hs0 && eh <= m.hs1) ? m.hp : !m.hp));
        chk({p, "vSync"}, 32'(vs), 32'((ev >= m.vs0 && ev <= m.vs1) ? m.vp : !m.vp));
        chk({p, "active"}, 32'(ac), 32'(ea));
        chk({p, "xPos"}, x, ea ? eh : 0);
        chk({p, "yPos"}, y, ea ? ev : 0);
        chk({p, "lineStart"}, 32'(ls), 32'(m.ls && en));
        chk({p, "frameStart"}, 32'(fs), 32'(m.fs && en));
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge(ma, rst_a, en_a);
        model_edge(mb, rst_b, en_b);
        @(negedge Clk);
        check_dut(ma, rst_a, en_a, "a.", tick_a, vclk_a, 32'(h_a), 32'(v_a), hs_a, vs_a, act_a,
                  32'(x_a), 32'(y_a), ls_a, fs_a);
        check_dut(mb, rst_b, en_b, "b.", tick_b, vclk_b, 32'(h_b), 32'(v_b), hs_b, vs_b, act_b,
                  32'(x_b), 32'(y_b), ls_b, fs_b);
        if (v_a == 10'd0 && !hs_a) hs_low_cnt++;
        if (ls_a) ls_cnt_a++;
    endtask

    initial begin
        int n;
        ma = mk(4, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
        mb = mk(1, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1, 1'b1);
        rst_a = 1;  en_a = 1;  rst_b = 1;  en_b = 0;
        tick();
        tick();
        chk("a.reset_hsync", 32'(hs_a), 1);
        chk("b.reset_hsync", 32'(hs_b), 0);

        // Default timing: run to hCount 300 while the small raster sees random enables.
        rst_a = 0;  rst_b = 0;
        hs_low_cnt = 0;  ls_cnt_a = 0;
        for (int i = 0; i < 1500 && h_a != 10'd300; i++) begin
            en_b = ($urandom_range(0, 9) != 0);
            tick();
        end
        chk("a.reach_300", 32'(h_a), 300);

        en_a = 0;
        for (int i = 0; i < 10; i++) tick();
        chk("a.freeze_h", 32'(h_a), 300);
        chk("a.freeze_tick", 32'(tick_a), 0);
        en_a = 1;

        for (int i = 0; i < 4000 && !(v_a == 10'd1 && h_a == 10'd5); i++) begin
            en_b = ($urandom_range(0, 9) != 0);
            tick();
        end
        chk("a.second_line", 32'(v_a), 1);
        chk("a.hsync_low_cycles", hs_low_cnt, 96 * 4);
        chk("a.line_pulses", ls_cnt_a, 1);

        // Reset mid-line while disabled and mid-prescaler.
        for (int i = 0; i < 3000 && h_a != 10'd700; i++) tick();
        tick();
        tick();
        rst_a = 1;  en_a = 0;
        tick();
        chk("a.rst_h", 32'(h_a), 0);
        chk("a.rst_v", 32'(v_a), 0);
        chk("a.rst_hsync", 32'(hs_a), 1);
        chk("a.rst_active", 32'(act_a), 1);
        rst_a = 0;

        // Small raster: frame period and mid-frame reset.
        en_b = 1;
        for (int i = 0; i < 200 && !fs_b; i++) tick();
        chk("b.frame_seen", 32'(fs_b), 1);
        n = 0;
        do begin
            tick();
            n++;
        end while (!fs_b && n < 200);
        chk("b.frame_period", n, 98);

        for (int i = 0; i < 200 && !(v_b == 4'd5 && h_b == 4'd11); i++) tick();
        chk("b.at_vsync", 32'(vs_b), 1);
        rst_b = 1;
        tick();
        chk("b.rst_h", 32'(h_b), 0);
        chk("b.rst_v", 32'(v_b), 0);
        chk("b.rst_hsync", 32'(hs_b), 0);
        chk("b.rst_vsync", 32'(vs_b), 0);
        rst_b = 0;
        tick();
        chk("b.release_frame", 32'(fs_b), 0);
        chk("b.release_line", 32'(ls_b), 0);

        // Random enables and occasional resets on both instances.
        for (int i = 0; i < 2500; i++) begin
            en_a  = ($urandom_range(0, 3) != 0);
            en_b  = ($urandom_range(0, 3) != 0);
            rst_a = ($urandom_range(0, 299) == 0);
            rst_b = ($urandom_range(0, 149) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
